// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
// Holds the default counter width, the smallest runnable divisor and the high-phase length rule.
package clk_div_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DIV_MIN   = 2;

    // Odd divisors spend the extra cycle in the high phase.
    function automatic logic [31:0] half_hi(input logic [31:0] div);
        return (div + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor and registered clk_out/tick.
// Latency: outputs registered, first tick one cycle after the channel starts running.
// Backpressure: none; free-running, divisor writes are shadowed until a period boundary.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W:0]   hi;
    logic             run;
    logic             last;
    logic             boundary;

    always_comb begin
        hi       = (CNT_W+1)'(half_hi(32'(act_div)));
        run      = en && (act_div >= CNT_W'(DIV_MIN));
        last     = (cnt == act_div - CNT_W'(1));
        // A stopped channel is always at a boundary, so writes to it land immediately.
        boundary = !run || last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            act_div <= DEF_DIV;
            shadow  <= '0;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (run) begin
                cnt     <= last ? '0 : cnt + CNT_W'(1);
                clk_out <= ({1'b0, cnt} < hi);
                tick    <= (cnt == '0);
            end else begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end

            if (wr) begin
                if (boundary) begin
                    act_div <= wr_div;
                    pending <= 1'b0;
                end else begin
                    shadow  <= wr_div;
                    pending <= 1'b1;
                end
            end else if (boundary && pending) begin
                act_div <= shadow;
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable integer clock divider; decodes divisor writes to per-channel strobes.
// Latency: registered outputs, one cycle from enable to first tick/clk_out rise.
// Backpressure: none; one config write per cycle, out-of-range channel writes are dropped.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int                     NCH     = 3,
    parameter int                     CNT_W   = CNT_W_DEF,
    parameter logic [NCH*CNT_W-1:0]   DEF_DIV = {8'd10, 8'd4, 8'd2},
    parameter int                     CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending
);

    logic [NCH-1:0] wr;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // Channel indices at or above NCH never match, so such writes vanish here.
        assign wr[i] = cfg_wr && (cfg_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV[i*CNT_W +: CNT_W])
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .wr      (wr[i]),
            .wr_div  (cfg_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: reset/default table, hand-written divisor corner sequences, random traffic vs a waveform-queue model.
module tb_clk_div_multi;

    logic       clk;
    logic       rst;
    logic [2:0] en;
    logic       cfg_wr;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [2:0] clk_out;
    logic [2:0] tick;
    logic [2:0] pending;

    int checks = 0;
    int errs   = 0;

    clk_div_multi #(.NCH(3), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each running channel plays back a queue holding one whole period of {clk,tick}.
    int         defs [3] = '{2, 4, 10};
    int         m_act [3];
    int         m_sh [3];
    logic [2:0] m_pend = '0;
    logic [2:0] m_clk  = '0;
    logic [2:0] m_tick = '0;
    logic [1:0] m_q [3][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [2:0] e, input logic w,
                              input logic [1:0] c, input logic [7:0] d);
        for (int ch = 0; ch < 3; ch++) begin
            bit         bnd;
            logic [1:0] v;
            if (r) begin
                m_act[ch] = defs[ch];
                m_sh[ch]  = 0;
                m_pend[ch] = 1'b0;
                m_q[ch].delete();
                m_clk[ch]  = 1'b0;
                m_tick[ch] = 1'b0;
            end else begin
                if (!(e[ch] && m_act[ch] >= 2)) begin
                    m_q[ch].delete();
                    m_clk[ch]  = 1'b0;
                    m_tick[ch] = 1'b0;
                    bnd = 1'b1;
                end else begin
                    if (m_q[ch].size() == 0)
                        for (int p = 0; p < m_act[ch]; p++)
                            m_q[ch].push_back({(p < (m_act[ch] + 1) / 2) ? 1'b1 : 1'b0,
                                               (p == 0) ? 1'b1 : 1'b0});
                    v = m_q[ch].pop_front();
                    m_clk[ch]  = v[1];
                    m_tick[ch] = v[0];
                    bnd = (m_q[ch].size() == 0);
                end
                if (w && int'(c) == ch) begin
                    if (bnd) begin
                        m_act[ch]  = int'(d);
                        m_pend[ch] = 1'b0;
                    end else begin
                        m_sh[ch]   = int'(d);
                        m_pend[ch] = 1'b1;
                    end
                end else if (bnd && m_pend[ch]) begin
                    m_act[ch]  = m_sh[ch];
                    m_pend[ch] = 1'b0;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [2:0] e, input logic w,
                       input logic [1:0] c, input logic [7:0] d);
        rst = r; en = e; cfg_wr = w; cfg_ch = c; cfg_div = d;
        @(posedge clk);
        model_step(r, e, w, c, d);
        #1;
        chk("model_clk_out", 32'(clk_out), 32'(m_clk));
        chk("model_tick",    32'(tick),    32'(m_tick));
        chk("model_pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic run7(input int n);
        repeat (n) cyc(1'b0, 3'b111, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 3'b000, 1'b0, 2'd0, 8'd0);
    endtask

    typedef struct {
        logic [2:0] en;
        logic       wr;
        logic [1:0] ch;
        logic [7:0] div;
        logic [2:0] exp_clk;
        logic [2:0] exp_tick;
        logic [2:0] exp_pend;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [9:0] p0, p1, p2;
        int         tk;
        logic [2:0] en_r;
        logic       r, w;
        logic [1:0] c;
        logic [7:0] d;
        int         sel;

        tbl[0]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000};
        tbl[1]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b110, 3'b000, 3'b000};
        tbl[2]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b101, 3'b001, 3'b000};
        tbl[3]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b100, 3'b000, 3'b000};
        tbl[4]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b011, 3'b000};
        tbl[5]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b010, 3'b000, 3'b000};
        tbl[6]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001, 3'b000};
        tbl[7]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
        tbl[8]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b011, 3'b011, 3'b000};
        tbl[9]  = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b010, 3'b000, 3'b000};
        tbl[10] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b101, 3'b101, 3'b000};

        // Reset state and default divisors 2/4/10
        do_reset();
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick",    32'(tick),    0);
        chk("rst_pending", 32'(pending), 0);
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, tbl[i].en, tbl[i].wr, tbl[i].ch, tbl[i].div);
            chk("tbl_clk_out", 32'(clk_out), 32'(tbl[i].exp_clk));
            chk("tbl_tick",    32'(tick),    32'(tbl[i].exp_tick));
            chk("tbl_pending", 32'(pending), 32'(tbl[i].exp_pend));
        end

        // Odd divisor 5 on ch1, written mid-period
        do_reset();
        run7(1);
        cyc(1'b0, 3'b111, 1'b1, 2'd1, 8'd5);
        chk("t2_pend_set", 32'(pending[1]), 1);
        run7(2);
        chk("t2_pend_clr", 32'(pending[1]), 0);
        p1 = '0; tk = 0;
        for (int i = 0; i < 10; i++) begin
            run7(1);
            if (i < 5) p1 = {p1[8:0], clk_out[1]};
            tk += int'(tick[1]);
        end
        chk("t2_shape", 32'(p1[4:0]), 32'b11100);
        chk("t2_ticks", tk, 2);

        // Shadow overwrite on ch2: 6 then 8, only 8 applied at cnt 9
        do_reset();
        run7(3);
        cyc(1'b0, 3'b111, 1'b1, 2'd2, 8'd6);
        run7(1);
        cyc(1'b0, 3'b111, 1'b1, 2'd2, 8'd8);
        run7(3);
        chk("t3_pend_hold", 32'(pending[2]), 1);
        run7(1);
        chk("t3_pend_clr", 32'(pending[2]), 0);
        p2 = '0;
        for (int i = 0; i < 8; i++) begin
            run7(1);
            p2 = {p2[8:0], clk_out[2]};
        end
        chk("t3_shape", 32'(p2[7:0]), 32'b11110000);
        run7(1);
        chk("t3_next_tick", 32'(tick[2]), 1);

        // Write exactly at the boundary bypasses the shadow
        do_reset();
        run7(9);
        cyc(1'b0, 3'b111, 1'b1, 2'd2, 8'd4);
        chk("t4_no_pend", 32'(pending[2]), 0);
        p2 = '0;
        for (int i = 0; i < 4; i++) begin
            run7(1);
            p2 = {p2[8:0], clk_out[2]};
        end
        chk("t4_shape", 32'(p2[3:0]), 32'b1100);
        run7(1);
        chk("t4_next_tick", 32'(tick[2]), 1);

        // Stop ch0 with div 1, restart with 3, then en0 toggle restarts phase
        do_reset();
        cyc(1'b0, 3'b111, 1'b1, 2'd0, 8'd1);
        chk("t5_pend", 32'(pending[0]), 1);
        run7(1);
        for (int i = 0; i < 3; i++) begin
            run7(1);
            chk("t5_stop_clk",  32'(clk_out[0]), 0);
            chk("t5_stop_tick", 32'(tick[0]),    0);
        end
        cyc(1'b0, 3'b111, 1'b1, 2'd0, 8'd3);
        chk("t5_direct", 32'(pending[0]), 0);
        p0 = '0;
        for (int i = 0; i < 3; i++) begin
            run7(1);
            p0 = {p0[8:0], clk_out[0]};
            if (i == 0) chk("t5_first_tick", 32'(tick[0]), 1);
        end
        chk("t5_shape", 32'(p0[2:0]), 32'b110);
        run7(1);
        cyc(1'b0, 3'b110, 1'b0, 2'd0, 8'd0);
        chk("t5_en_low", 32'(clk_out[0]), 0);
        run7(1);
        chk("t5_restart_tick", 32'(tick[0]), 1);
        chk("t5_restart_clk",  32'(clk_out[0]), 1);

        // Reset mid-operation drops the pending write and the write in the reset cycle
        do_reset();
        run7(1);
        cyc(1'b0, 3'b111, 1'b1, 2'd1, 8'd7);
        chk("t6_pend_set", 32'(pending), 32'b010);
        cyc(1'b1, 3'b111, 1'b1, 2'd0, 8'd9);
        chk("t6_rst_clk",  32'(clk_out), 0);
        chk("t6_rst_tick", 32'(tick),    0);
        chk("t6_rst_pend", 32'(pending), 0);
        p0 = '0; p1 = '0; p2 = '0;
        for (int i = 0; i < 10; i++) begin
            run7(1);
            p0 = {p0[8:0], clk_out[0]};
            p1 = {p1[8:0], clk_out[1]};
            p2 = {p2[8:0], clk_out[2]};
        end
        chk("t6_ch0", 32'(p0), 32'b1010101010);
        chk("t6_ch1", 32'(p1), 32'b1100110011);
        chk("t6_ch2", 32'(p2), 32'b1111100000);
        // Channel 3 does not exist
        p0 = '0; p1 = '0; p2 = '0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 3'b111, (i == 0 || i == 3), 2'd3, 8'd3);
            chk("t6_badch_pend", 32'(pending), 0);
            p0 = {p0[8:0], clk_out[0]};
            p1 = {p1[8:0], clk_out[1]};
            p2 = {p2[8:0], clk_out[2]};
        end
        chk("t6_badch_ch0", 32'(p0), 32'b1010101010);
        chk("t6_badch_ch1", 32'(p1), 32'b0011001100);
        chk("t6_badch_ch2", 32'(p2), 32'b1111100000);

        // Random traffic against the model
        en_r = 3'b111;
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            for (int ch = 0; ch < 3; ch++)
                if ($urandom_range(0, 39) == 0) en_r[ch] = ~en_r[ch];
            w   = ($urandom_range(0, 5) == 0);
            c   = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            if (sel == 0)      d = 8'($urandom_range(0, 1));
            else if (sel == 9) d = 8'($urandom_range(10, 255));
            else               d = 8'($urandom_range(2, 9));
            cyc(r, en_r, w, c, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
